logic_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for a shared `unit_logic` instance. It accepts logic operations from two independent valid/ready ports and decodes a 3-bit opcode into the `c_and`/`c_or`/`c_xor`/`c_inv` controls. Each accepted operation passes through a two-stage stallable pipeline (issue register, then result register). The block sits between ALU front-end requesters and the single logic datapath, and returns each result tagged with the originating requester.

---
 rtl/logic_arb.sv | 135 +++++++++++++
 tb/tb_logic_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_arb.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit.
// Each accepted operation flows through an issue register and a result register.

module unit_logic #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_and,
    input  logic             i_or,
    input  logic             i_xor,
    input  logic             i_inv,
    output logic [WIDTH-1:0] o_y
);
    logic [WIDTH-1:0] w_raw;

    always_comb begin
        w_raw = '0;
        if (i_and) w_raw = i_a & i_b;
        if (i_or)  w_raw = i_a | i_b;
        if (i_xor) w_raw = i_a ^ i_b;
    end

    assign o_y = i_inv ? ~w_raw : w_raw;
endmodule

module logic_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);
    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on operand values.
    logic             r_prio;
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_id;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;

    logic             w_res_adv;
    logic             w_s1_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_acc;
    logic             w_c_and;
    logic             w_c_or;
    logic             w_c_xor;
    logic             w_c_inv;
    logic [WIDTH-1:0] w_unit_y;

    assign w_res_adv   = !r_res_valid || res_ready;
    assign w_s1_accept = !r_s1_valid || w_res_adv;
    assign w_grant0    = req0_valid && (!r_prio || !req1_valid);
    assign w_grant1    = req1_valid && (r_prio || !req0_valid);
    // rst_n gates ready so nothing can look accepted while the block is held in reset.
    assign req0_ready  = w_grant0 && w_s1_accept && rst_n;
    assign req1_ready  = w_grant1 && w_s1_accept && rst_n;
    assign w_acc       = req0_ready || req1_ready;

    assign w_c_inv = r_s1_op[2];
    assign w_c_and = (r_s1_op[1:0] == 2'b00);
    assign w_c_or  = (r_s1_op[1:0] == 2'b01);
    assign w_c_xor = (r_s1_op[1:0] == 2'b10);

    unit_logic #(.WIDTH(WIDTH)) u_unit (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .i_and (w_c_and),
        .i_or  (w_c_or),
        .i_xor (w_c_xor),
        .i_inv (w_c_inv),
        .o_y   (w_unit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= 1'b0;
        end else begin
            if (w_acc) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= req1_ready ? req1_op : req0_op;
                r_s1_a     <= req1_ready ? req1_a : req0_a;
                r_s1_b     <= req1_ready ? req1_b : req0_b;
                r_s1_id    <= req1_ready;
                r_prio     <= !req1_ready;
            end else if (w_res_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
        end else if (r_s1_valid && w_res_adv) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_unit_y;
            r_res_id    <= r_s1_id;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_s1_valid || r_res_valid;
endmodule

// File: tb/tb_logic_arb.sv
// Directed bench for logic_arb: vector table for the opcode sweep plus
// hand-written sequences for arbitration, backpressure and reset.

module tb_logic_arb;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [2:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [2:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         busy;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[8];
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;
  int           total;
  int           bad;
  int           consumed;
  int           c0;
  int           idx;
  logic         acc_now;

  logic_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: a result is consumed on the edge following this negedge
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      consumed++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_unexpected: got id=%0d data=%02h expected none", res_id, res_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_id", {31'd0, res_id}, {31'd0, mon_e[W]});
        check("res_data", {24'd0, res_data}, {24'd0, mon_e[W-1:0]});
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      cyc();
      n++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; consumed = 0;
    vecs[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC};
    vecs[3] = '{3'b011, 8'hF0, 8'h3C, 8'h00};
    vecs[4] = '{3'b100, 8'hF0, 8'h3C, 8'hCF};
    vecs[5] = '{3'b101, 8'hF0, 8'h3C, 8'h03};
    vecs[6] = '{3'b110, 8'hF0, 8'h3C, 8'h33};
    vecs[7] = '{3'b111, 8'hF0, 8'h3C, 8'hFF};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    #1;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // single request, first edge after release
    #1;
    check("single_ready", {31'd0, req0_ready}, 32'd1);
    exp_q.push_back({1'b0, 8'h30});
    cyc();
    req0_valid = 1'b0;
    check("single_e0_res_valid", {31'd0, res_valid}, 32'd0);
    check("single_e0_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("single_e1_res_valid", {31'd0, res_valid}, 32'd1);
    check("single_e1_res_data", {24'd0, res_data}, 32'h30);
    check("single_e1_res_id", {31'd0, res_id}, 32'd0);
    drain();

    // opcode sweep on requester 1, back to back
    c0 = consumed;
    for (int i = 0; i < 8; i++) begin
      req1_valid = 1'b1;
      req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
      #1;
      check("sweep_ready", {31'd0, req1_ready}, 32'd1);
      exp_q.push_back({1'b1, vecs[i].exp});
      cyc();
    end
    req1_valid = 1'b0;
    cyc();
    cyc();
    check("sweep_throughput", consumed - c0, 32'd8);
    drain();

    // fairness with both requesters continuously valid
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'hA0; req0_b = 8'h05;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h5F; req1_b = 8'hF3;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fair_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("fair_req1_ready", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) exp_q.push_back({1'b0, 8'hA5});
      else            exp_q.push_back({1'b1, 8'h53});
      cyc();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("fair_prio_even", {31'd0, dut.r_prio}, 32'd0);
    drain();

    // backpressure: consumer stalled for 6 cycles
    res_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = W'(idx + 1); req0_b = 8'h00;
      #1;
      acc_now = req0_ready;
      if (acc_now) exp_q.push_back({1'b0, W'(idx + 1)});
      if (i >= 2) begin
        check("bp_stall_ready", {31'd0, req0_ready}, 32'd0);
        check("bp_stall_valid", {31'd0, res_valid}, 32'd1);
        check("bp_stall_data", {24'd0, res_data}, 32'h01);
      end
      cyc();
      if (acc_now) idx++;
    end
    check("bp_accepts", idx, 32'd2);
    res_ready = 1'b1;
    c0 = consumed;
    for (int n = 0; n < 20 && idx < 5; n++) begin
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = W'(idx + 1); req0_b = 8'h00;
      #1;
      acc_now = req0_ready;
      if (acc_now) exp_q.push_back({1'b0, W'(idx + 1)});
      cyc();
      if (acc_now) idx++;
    end
    req0_valid = 1'b0;
    check("bp_all_accepted", idx, 32'd5);
    drain();
    check("bp_delivered", consumed - c0, 32'd5);

    // lone requester 1 is granted regardless of prio
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 8'h55; req1_b = 8'hAA;
    #1;
    check("lone_req1_ready_a", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'h00});
    cyc();
    check("lone_prio_a", {31'd0, dut.r_prio}, 32'd0);
    req1_op = 3'b111;
    #1;
    check("lone_req1_ready_b", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'hFF});
    cyc();
    check("lone_prio_b", {31'd0, dut.r_prio}, 32'd0);
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 8'h0F; req0_b = 8'hFF;
    req1_op = 3'b100; req1_a = 8'hFF; req1_b = 8'h00;
    #1;
    check("contend_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("contend_req1_ready", {31'd0, req1_ready}, 32'd0);
    exp_q.push_back({1'b0, 8'hF0});
    cyc();
    req0_valid = 1'b0;
    #1;
    check("contend_req1_next", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'hFF});
    cyc();
    req1_valid = 1'b0;
    drain();

    // asynchronous reset with both stages full
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h11; req0_b = 8'h22;
    cyc();
    cyc();
    cyc();
    req0_valid = 1'b0;
    check("mid_full_valid", {31'd0, res_valid}, 32'd1);
    check("mid_full_s1", {31'd0, dut.r_s1_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_res_data", {24'd0, res_data}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    res_ready = 1'b1;
    c0 = consumed;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h3C; req1_b = 8'h0F;
    #1;
    check("post_rst_ready", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'h0C});
    cyc();
    req1_valid = 1'b0;
    drain();
    cyc();
    cyc();
    check("post_rst_one_result", consumed - c0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
